// File: rtl/fir_sequencer_pkg.sv
// Shared widths, state encoding and bound helpers for the FIR convolution sequencer.
package fir_pkg;

   localparam int WSP_W    = 6;
   localparam int PROBKA_W = 14;
   localparam int RAZY_W   = 15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_WRITE  = 3'd4,
      ST_FINISH = 3'd5
   } fir_seq_state_t;

   // Lowest tap index reaching a valid sample: n-N+1 once n has passed the last sample.
   // The true value is below 64, so the subtraction can be done in tap width.
   function automatic logic [WSP_W-1:0] k_lower(input logic [RAZY_W-1:0]   n,
                                               input logic [PROBKA_W-1:0] nsmp);
      logic [WSP_W-1:0] lo;
      if (n >= {1'b0, nsmp}) begin
         lo = n[WSP_W-1:0] - nsmp[WSP_W-1:0] + 6'd1;
      end else begin
         lo = 6'd0;
      end
      return lo;
   endfunction

   function automatic logic [WSP_W-1:0] k_upper(input logic [WSP_W-1:0]  m,
                                               input logic [RAZY_W-1:0] n);
      logic [WSP_W-1:0] m_last;
      logic [WSP_W-1:0] hi;
      m_last = m - 6'd1;
      if ({9'd0, m_last} < n) begin
         hi = m_last;
      end else begin
         hi = n[WSP_W-1:0];
      end
      return hi;
   endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Handshake and RAM/MAC control bundle between the register block, sequencer and datapath.
interface fir_sequencer_if;
   import fir_pkg::*;

   logic                start;
   logic [WSP_W-1:0]    ile_wsp;
   logic [PROBKA_W-1:0] ile_probek;
   logic [RAZY_W-1:0]   ile_razy;
   logic                pracuje;
   logic                done;
   logic [WSP_W-1:0]    wsp_addr;
   logic                wsp_re;
   logic [PROBKA_W-1:0] probka_addr;
   logic                probka_re;
   logic                mac_en;
   logic                mac_first;
   logic [RAZY_W-1:0]   wyn_addr;
   logic                wyn_we;

   modport master (
      output start, ile_wsp, ile_probek, ile_razy,
      input  pracuje, done, wsp_addr, wsp_re, probka_addr, probka_re,
             mac_en, mac_first, wyn_addr, wyn_we
   );

   modport slave (
      input  start, ile_wsp, ile_probek, ile_razy,
      output pracuje, done, wsp_addr, wsp_re, probka_addr, probka_re,
             mac_en, mac_first, wyn_addr, wyn_we
   );

endinterface

// File: rtl/fir_sequencer_lat_pipe.sv
// Fixed-depth shift register that delays the {valid, first} issue flags to meet RAM read data.
module fir_lat_pipe #(
   parameter int DEPTH = 1,
   parameter int W     = 2
) (
   input  logic         clk_b,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_r [DEPTH];

   // Shift the flags one stage per cycle; reset flushes every stage.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= {W{1'b0}};
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/fir_sequencer.sv
// Control sequencer walking y[n] = sum h[k]*x[n-k]: issues RAM reads, MAC strobes and result writes.
module fir_sequencer
   import fir_pkg::*;
#(
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 1
) (
   input  logic           clk_b,
   input  logic           rst,
   fir_sequencer_if.slave bus
);

   localparam int         DRAIN_LEN  = RD_LAT + MAC_LAT;
   localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_LEN - 1);

   fir_seq_state_t      state_r, state_s;
   logic [WSP_W-1:0]    m_r, k_r, k_lo_r, k_hi_r;
   logic [PROBKA_W-1:0] nsmp_r;
   logic [RAZY_W-1:0]   r_r, n_r;
   logic [2:0]          drain_cnt_r;
   logic                empty_s;
   logic [PROBKA_W-1:0] probka_diff_s;

   logic                pracuje_r, done_r, wsp_re_r, probka_re_r, wyn_we_r, issue_first_r;
   logic [WSP_W-1:0]    wsp_addr_r;
   logic [PROBKA_W-1:0] probka_addr_r;
   logic [RAZY_W-1:0]   wyn_addr_r;
   logic [1:0]          mac_flags_s;

   assign empty_s = (bus.ile_wsp == 6'd0) || (bus.ile_probek == 14'd0) || (bus.ile_razy == 15'd0);
   // n-k is known to lie in 0..N-1, so only the sample-address bits are kept.
   assign probka_diff_s = n_r[PROBKA_W-1:0] - {8'd0, k_r};

   // State register.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = empty_s ? ST_FINISH : ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP:  state_s = ST_ISSUE;
         ST_ISSUE: begin
            if (k_r >= k_hi_r) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_r == DRAIN_LAST) begin
               state_s = ST_WRITE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_WRITE: begin
            if (n_r == r_r - 15'd1) begin
               state_s = ST_FINISH;
            end else begin
               state_s = ST_SETUP;
            end
         end
         ST_FINISH: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Run parameters and convolution counters.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         m_r         <= 6'd0;
         nsmp_r      <= 14'd0;
         r_r         <= 15'd0;
         n_r         <= 15'd0;
         k_r         <= 6'd0;
         k_lo_r      <= 6'd0;
         k_hi_r      <= 6'd0;
         drain_cnt_r <= 3'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  m_r    <= bus.ile_wsp;
                  nsmp_r <= bus.ile_probek;
                  r_r    <= bus.ile_razy;
                  n_r    <= 15'd0;
               end
            end
            ST_SETUP: begin
               k_lo_r <= k_lower(n_r, nsmp_r);
               k_hi_r <= k_upper(m_r, n_r);
               k_r    <= k_lower(n_r, nsmp_r);
            end
            ST_ISSUE: begin
               k_r         <= k_r + 6'd1;
               drain_cnt_r <= 3'd0;
            end
            ST_DRAIN: drain_cnt_r <= drain_cnt_r + 3'd1;
            ST_WRITE: begin
               if (n_r != r_r - 15'd1) begin
                  n_r <= n_r + 15'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered control outputs, each reflecting the state of the previous cycle.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         pracuje_r     <= 1'b0;
         done_r        <= 1'b0;
         wsp_re_r      <= 1'b0;
         probka_re_r   <= 1'b0;
         issue_first_r <= 1'b0;
         wsp_addr_r    <= 6'd0;
         probka_addr_r <= 14'd0;
         wyn_we_r      <= 1'b0;
         wyn_addr_r    <= 15'd0;
      end else begin
         pracuje_r     <= (state_r == ST_SETUP) || (state_r == ST_ISSUE) ||
                          (state_r == ST_DRAIN) || (state_r == ST_WRITE);
         done_r        <= (state_r == ST_FINISH);
         wsp_re_r      <= (state_r == ST_ISSUE);
         probka_re_r   <= (state_r == ST_ISSUE);
         issue_first_r <= (state_r == ST_ISSUE) && (k_r == k_lo_r);
         wsp_addr_r    <= (state_r == ST_ISSUE) ? k_r : 6'd0;
         probka_addr_r <= (state_r == ST_ISSUE) ? probka_diff_s : 14'd0;
         wyn_we_r      <= (state_r == ST_WRITE);
         wyn_addr_r    <= (state_r == ST_WRITE) ? n_r : 15'd0;
      end
   end

   fir_lat_pipe #(.DEPTH(RD_LAT), .W(2)) u_lat_pipe (
      .clk_b (clk_b),
      .rst   (rst),
      .d     ({wsp_re_r, issue_first_r}),
      .q     (mac_flags_s)
   );

   assign bus.pracuje     = pracuje_r;
   assign bus.done        = done_r;
   assign bus.wsp_re      = wsp_re_r;
   assign bus.wsp_addr    = wsp_addr_r;
   assign bus.probka_re   = probka_re_r;
   assign bus.probka_addr = probka_addr_r;
   assign bus.mac_en      = mac_flags_s[1];
   assign bus.mac_first   = mac_flags_s[0];
   assign bus.wyn_we      = wyn_we_r;
   assign bus.wyn_addr    = wyn_addr_r;

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Control stage directly downstream of the FIR control-register block.
- Consumes Start, ile_wsp (M coefficients), ile_probek (N samples) and ile_razy (M+N-1); returns pracuje and a DONE pulse.
- Walks the full linear convolution y[n] = sum h[k]*x[n-k] for n = 0..M+N-2. Drives coefficient-RAM and sample-RAM read addresses, MAC control strobes and result-RAM writes.
- Pure control path: no data words pass through the block.

Parameters:
- RD_LAT, 1, read latency of coefficient/sample RAMs in cycles (1..3).
- MAC_LAT, 1, cycles from the last mac_en to a valid accumulator result (1..3).

Ports:
- clk_b  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start request from the control registers.
- ile_wsp  in  6  M, coefficient count.
- ile_probek  in  14  N, sample count.
- ile_razy  in  15  output count, M+N-1 (0 when M=N=0).
- pracuje  out  1  high while a convolution is in progress.
- done  out  1  one-cycle completion pulse.
- wsp_addr  out  6  coefficient RAM read address (k).
- wsp_re  out  1  coefficient RAM read enable.
- probka_addr  out  14  sample RAM read address (n-k).
- probka_re  out  1  sample RAM read enable.
- mac_en  out  1  MAC operand valid; accumulate this product.
- mac_first  out  1  with mac_en: load the product instead of adding it.
- wyn_addr  out  15  result RAM write address (n).
- wyn_we  out  1  result RAM write strobe.

Behaviour:
- All outputs are registered.
- Reset: all outputs 0, state IDLE, internal counters 0. Reset applied mid-run aborts the run immediately with no done pulse.
- States: IDLE, SETUP, ISSUE, DRAIN, WRITE, FINISH.
- IDLE:
  - start=1 latches M, N and R=ile_razy, and sets n=0.
  - If M=0, N=0 or R=0, go to FINISH.
  - Otherwise go to SETUP.
  - start is ignored in every other state.
- SETUP (1 cycle):
  - k_lo = (n >= N) ? n-N+1 : 0.
  - k_hi = min(M-1, n).
  - k = k_lo.
- ISSUE (k_hi-k_lo+1 cycles):
  - Each cycle: wsp_re = probka_re = 1, wsp_addr = k, probka_addr = n-k.
  - An issue flag is tagged "first" when k = k_lo.
  - Go to DRAIN after k = k_hi.
- Alignment:
  - mac_en and mac_first equal the issue flags delayed by exactly RD_LAT cycles.
  - The delay line also runs during DRAIN.
- DRAIN: exactly RD_LAT+MAC_LAT cycles, counted from the cycle after the last issue.
- WRITE (1 cycle):
  - wyn_we = 1, wyn_addr = n.
  - If n = R-1, go to FINISH; else n++ and go to SETUP.
- FINISH: done = 1 for one cycle, pracuje = 0, then IDLE.
- pracuje = 1 in SETUP, ISSUE, DRAIN and WRITE; 0 in IDLE and FINISH.
- Cycles per output: 2 + RD_LAT + MAC_LAT + terms(n). Terms summed over all n = M*N.
- Width rules:
  - n and R are 15 bits unsigned.
  - n-k is computed in 15 bits; range 0..N-1 is guaranteed by the k bounds, so it is truncated to 14 bits.
  - No wrap: maximum R is 16445 < 2^15.
- Changes to ile_* inputs while pracuje = 1 have no effect on the current run (values are latched at start).
- done is a pulse; the control-register block holds it sticky.

Decomposition:
- Shared package fir_pkg:
  - WSP_W=6, PROBKA_W=14, RAZY_W=15.
  - Typedef enum fir_seq_state_t for the six states.
- One sub-module, fir_lat_pipe: a parameterised-depth shift register (synchronous active-high reset) carrying the {valid, first} pair, used for RD_LAT alignment.

Test Plan:
- M=3, N=4, R=6, RD_LAT=MAC_LAT=1:
  - Start in IDLE -> pracuje high for exactly 36 consecutive cycles, then done high for 1 cycle.
  - wyn_we pulses 6 times with wyn_addr 0..5.
  - For n=2, (wsp_addr, probka_addr) sequence is (0,2), (1,1), (2,0).
  - For n=5, the only pair is (2,3).
- Same run -> mac_en high 12 cycles total; mac_first high 6 times, each RD_LAT cycles after the k_lo issue.
- M=0, N=5 -> done pulses the cycle after FINISH is entered (2nd cycle after start); pracuje, wsp_re and wyn_we stay 0.
- Start pulses during a run (M=2, N=2) -> ignored; exactly 3 wyn_we pulses and 1 done.
- rst asserted during ISSUE of n=1 -> next cycle all outputs 0 and state IDLE; a subsequent start runs a full, correct sequence.
- M=63, N=16383, RD_LAT=2, MAC_LAT=3 -> 16445 writes; last wyn_addr=16444 with pair (62,16382); done follows.
